mac_pe: RTL and testbench

- Pipelined multiply-accumulate processing element; the building block for the systolic matrix unit.
- Computes dot products over a stream of operand pairs, framed by in_last, with an optional signed mode and an optional saturating accumulator.
- Registers the operands onward to the neighbouring PE.
- Emits one result per frame through a valid/ready output handshake with full backpressure.

---
 rtl/mac_pkg.sv | 52 +++++
 rtl/mac_pe_if.sv | 29 ++
 rtl/mac_mul_stage.sv | 43 ++++
 rtl/mac_pe.sv | 117 +++++++++++
 tb/tb_mac_pe.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared helpers for the MAC processing element: width-generic limits and
// the overflow-aware accumulate used by the accumulator stage.
package mac_pkg;

    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] word_t;

    typedef struct packed {
        logic  ovf;
        word_t res;
    } sum_t;

    function automatic word_t umax(input int unsigned w);
        return {MAX_W{1'b1}} >> (MAX_W - w);
    endfunction

    function automatic word_t smax(input int unsigned w);
        return umax(w) >> 1;
    endfunction

    function automatic word_t smin(input int unsigned w);
        return word_t'(1) << (w - 1);
    endfunction

    function automatic logic bit_at(input word_t x, input int unsigned i);
        word_t t;
        t = x >> i;
        return t[0];
    endfunction

    // Operands occupy the low w bits; the result is returned in the low w bits.
    function automatic sum_t sat_add(input word_t acc, input word_t prod,
                                     input int unsigned w, input logic sgn,
                                     input logic sat);
        logic [MAX_W:0] sum;
        word_t          res;
        logic           carry;
        logic           sa;
        logic           ovf;
        sum   = {1'b0, acc & umax(w)} + {1'b0, prod & umax(w)};
        res   = sum[MAX_W-1:0] & umax(w);
        carry = |(sum >> w);
        sa    = bit_at(acc, w - 1);
        ovf   = sgn ? ((sa == bit_at(prod, w - 1)) && (bit_at(res, w - 1) != sa))
                    : carry;
        if (ovf && sat)
            res = sgn ? (sa ? smin(w) : smax(w)) : umax(w);
        return '{ovf: ovf, res: res};
    endfunction

endpackage

// File: rtl/mac_pe_if.sv
// Operand stream, forwarding and result handshake of one MAC PE.
interface mac_pe_if #(
    parameter int OP_WIDTH  = 8,
    parameter int ACC_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [OP_WIDTH-1:0]  in_a;
    logic [OP_WIDTH-1:0]  in_b;
    logic                 in_last;
    logic                 acc_clear;
    logic [OP_WIDTH-1:0]  a_fwd;
    logic [OP_WIDTH-1:0]  b_fwd;
    logic                 fwd_valid;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_acc;
    logic                 out_sat;

    modport master (
        output in_valid, in_a, in_b, in_last, acc_clear, out_ready,
        input  in_ready, a_fwd, b_fwd, fwd_valid, out_valid, out_acc, out_sat
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, acc_clear, out_ready,
        output in_ready, a_fwd, b_fwd, fwd_valid, out_valid, out_acc, out_sat
    );
endinterface

// File: rtl/mac_mul_stage.sv
// Stage 1 of the MAC: full-width product register with valid/last sideband,
// held while the pipeline is frozen.
module mac_mul_stage import mac_pkg::*; #(
    parameter int OP_WIDTH = 8,
    parameter int SIGNED   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [OP_WIDTH-1:0]   in_a,
    input  logic [OP_WIDTH-1:0]   in_b,
    output logic [2*OP_WIDTH-1:0] prod,
    output logic                  vld,
    output logic                  last
);
    localparam int PW = 2 * OP_WIDTH;

    logic [PW-1:0] p;

    // Low PW bits of the extended-operand product are the exact product.
    if (SIGNED != 0) begin : g_smul
        assign p = PW'($signed(in_a)) * PW'($signed(in_b));
    end else begin : g_umul
        assign p = PW'(in_a) * PW'(in_b);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod <= '0;
            vld  <= 1'b0;
            last <= 1'b0;
        end else if (clear) begin
            vld  <= 1'b0;
        end else if (en) begin
            prod <= p;
            vld  <= in_valid;
            last <= in_last;
        end
    end
endmodule

// File: rtl/mac_pe.sv
// Pipelined multiply-accumulate PE: product stage, accumulator/output stage,
// operand forwarding and a backpressured result handshake.
module mac_pe import mac_pkg::*; #(
    parameter int OP_WIDTH  = 8,
    parameter int ACC_WIDTH = 32,
    parameter int SIGNED    = 1,
    parameter int SATURATE  = 1
) (
    input logic    clk,
    input logic    reset,
    mac_pe_if.slave bus
);
    localparam int PW = 2 * OP_WIDTH;

    if (ACC_WIDTH < PW || ACC_WIDTH > MAX_W) begin : g_width_check
        $error("mac_pe: ACC_WIDTH must lie in [2*OP_WIDTH, 64]");
    end

    logic                 adv;
    logic                 accept;
    logic [PW-1:0]        s1_prod;
    logic                 s1_vld;
    logic                 s1_last;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] acc;
    logic                 sticky;
    logic                 ovf_now;
    word_t                sum_res;
    logic [ACC_WIDTH-1:0] res;
    logic [ACC_WIDTH-1:0] out_acc_q;
    logic                 out_sat_q;
    logic                 out_valid_q;
    logic [OP_WIDTH-1:0]  a_fwd_q;
    logic [OP_WIDTH-1:0]  b_fwd_q;
    logic                 fwd_valid_q;

    // A pending, unaccepted result freezes every stage.
    assign adv          = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = adv & ~bus.acc_clear;
    assign accept       = bus.in_valid & bus.in_ready;

    mac_mul_stage #(.OP_WIDTH(OP_WIDTH), .SIGNED(SIGNED)) u_mul (
        .clk      (clk),
        .reset    (reset),
        .en       (adv),
        .clear    (bus.acc_clear),
        .in_valid (accept),
        .in_last  (bus.in_last),
        .in_a     (bus.in_a),
        .in_b     (bus.in_b),
        .prod     (s1_prod),
        .vld      (s1_vld),
        .last     (s1_last)
    );

    if (SIGNED != 0) begin : g_sx
        assign prod_ext = ACC_WIDTH'($signed(s1_prod));
    end else begin : g_zx
        assign prod_ext = ACC_WIDTH'(s1_prod);
    end

    assign {ovf_now, sum_res} = sat_add(word_t'(acc), word_t'(prod_ext), ACC_WIDTH,
                                        SIGNED != 0, SATURATE != 0);
    assign res = sum_res[ACC_WIDTH-1:0];

    a_res_in_range: assert property (@(posedge clk) disable iff (!reset)
        (sum_res >> ACC_WIDTH) == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc         <= '0;
            sticky      <= 1'b0;
            out_acc_q   <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (bus.acc_clear) begin
            acc    <= '0;
            sticky <= 1'b0;
            if (bus.out_ready) out_valid_q <= 1'b0;
        end else if (adv) begin
            out_valid_q <= 1'b0;
            if (s1_vld) begin
                if (s1_last) begin
                    out_acc_q   <= res;
                    out_sat_q   <= sticky | ovf_now;
                    out_valid_q <= 1'b1;
                    acc         <= '0;
                    sticky      <= 1'b0;
                end else begin
                    acc    <= res;
                    sticky <= sticky | ovf_now;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_fwd_q     <= '0;
            b_fwd_q     <= '0;
            fwd_valid_q <= 1'b0;
        end else begin
            fwd_valid_q <= accept;
            if (accept) begin
                a_fwd_q <= bus.in_a;
                b_fwd_q <= bus.in_b;
            end
        end
    end

    assign bus.out_acc   = out_acc_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_valid = out_valid_q;
    assign bus.a_fwd     = a_fwd_q;
    assign bus.b_fwd     = b_fwd_q;
    assign bus.fwd_valid = fwd_valid_q;
endmodule

// File: tb/tb_mac_pe.sv
// Scoreboard bench for mac_pe: four configurations share one stimulus driver,
// expected results are queued at the last accept and popped by a monitor.
module tb_mac_pe;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       acc_clear = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [1:0] sel = 2'd0;

    int checks = 0;
    int failures = 0;

    logic [32:0] q0[$], q1[$], q2[$], q3[$];

    always #5 clk = ~clk;

    mac_pe_if #(.OP_WIDTH(8), .ACC_WIDTH(32)) if_m ();
    mac_pe_if #(.OP_WIDTH(8), .ACC_WIDTH(16)) if_s ();
    mac_pe_if #(.OP_WIDTH(8), .ACC_WIDTH(16)) if_w ();
    mac_pe_if #(.OP_WIDTH(8), .ACC_WIDTH(16)) if_u ();

    assign if_m.in_valid = in_valid && sel == 2'd0;
    assign if_s.in_valid = in_valid && sel == 2'd1;
    assign if_w.in_valid = in_valid && sel == 2'd2;
    assign if_u.in_valid = in_valid && sel == 2'd3;
    assign if_m.in_a = in_a;  assign if_s.in_a = in_a;  assign if_w.in_a = in_a;  assign if_u.in_a = in_a;
    assign if_m.in_b = in_b;  assign if_s.in_b = in_b;  assign if_w.in_b = in_b;  assign if_u.in_b = in_b;
    assign if_m.in_last = in_last;  assign if_s.in_last = in_last;
    assign if_w.in_last = in_last;  assign if_u.in_last = in_last;
    assign if_m.acc_clear = acc_clear;  assign if_s.acc_clear = acc_clear;
    assign if_w.acc_clear = acc_clear;  assign if_u.acc_clear = acc_clear;
    assign if_m.out_ready = out_ready;  assign if_s.out_ready = out_ready;
    assign if_w.out_ready = out_ready;  assign if_u.out_ready = out_ready;

    mac_pe #(.OP_WIDTH(8), .ACC_WIDTH(32), .SIGNED(1), .SATURATE(1)) dut_m (.clk(clk), .reset(reset), .bus(if_m));
    mac_pe #(.OP_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(1)) dut_s (.clk(clk), .reset(reset), .bus(if_s));
    mac_pe #(.OP_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(0)) dut_w (.clk(clk), .reset(reset), .bus(if_w));
    mac_pe #(.OP_WIDTH(8), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(1)) dut_u (.clk(clk), .reset(reset), .bus(if_u));

    function automatic logic rdy();
        case (sel)
            2'd0:    return if_m.in_ready;
            2'd1:    return if_s.in_ready;
            2'd2:    return if_w.in_ready;
            default: return if_u.in_ready;
        endcase
    endfunction

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input logic sat, input logic [31:0] acc);
        case (id)
            0:       q0.push_back({sat, acc});
            1:       q1.push_back({sat, acc});
            2:       q2.push_back({sat, acc});
            default: q3.push_back({sat, acc});
        endcase
    endtask

    task automatic mon_pop(input int id, input logic [32:0] act);
        logic [32:0] e;
        bit          have;
        have = 1'b0;
        e    = '0;
        case (id)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            2:       if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result dut%0d: got %0h expected none", id, act);
        end else begin
            chk($sformatf("result_dut%0d", id), act, e);
        end
    endtask

    // Monitor samples mid-low-phase, after the driver has settled its inputs.
    initial forever begin
        @(negedge clk);
        #3;
        if (if_m.out_valid && if_m.out_ready) mon_pop(0, {if_m.out_sat, if_m.out_acc});
        if (if_s.out_valid && if_s.out_ready) mon_pop(1, {if_s.out_sat, 32'(if_s.out_acc)});
        if (if_w.out_valid && if_w.out_ready) mon_pop(2, {if_w.out_sat, 32'(if_w.out_acc)});
        if (if_u.out_valid && if_u.out_ready) mon_pop(3, {if_u.out_sat, 32'(if_u.out_acc)});
    end

    task automatic send(input int a, input int b, input logic last);
        in_valid = 1'b1;
        in_a     = a[7:0];
        in_b     = b[7:0];
        in_last  = last;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (rdy()) begin
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected accept");
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1 reset = 1'b0;
        #2;
        chk("rst_out_valid", {32'd0, if_m.out_valid}, 33'd0);
        chk("rst_out_acc",   {if_m.out_sat, if_m.out_acc}, 33'd0);
        chk("rst_fwd",       {15'd0, if_m.fwd_valid, if_m.a_fwd, if_m.b_fwd, 1'b0}, 33'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // basic signed frame: 12 - 10 - 7 = -5
        send(3, 4, 1'b0);
        chk("fwd_pulse", {16'd0, if_m.fwd_valid, if_m.a_fwd, if_m.b_fwd}, {16'd0, 1'b1, 8'd3, 8'd4});
        send(-2, 5, 1'b0);
        send(7, -1, 1'b1);
        push(0, 1'b0, 32'hFFFF_FFFB);
        chk("latency_1edge", {32'd0, if_m.out_valid}, 33'd0);
        idle(1);
        chk("latency_2edge", {32'd0, if_m.out_valid}, 33'd1);
        chk("fwd_drop", {32'd0, if_m.fwd_valid}, 33'd0);
        idle(3);

        // back-to-back single-element frames
        send(1, 1, 1'b1); push(0, 1'b0, 32'd1);
        send(2, 3, 1'b1); push(0, 1'b0, 32'd6);
        send(4, 4, 1'b1); push(0, 1'b0, 32'd16);
        chk("b2b_valid0", {32'd0, if_m.out_valid}, 33'd1);
        idle(1);
        chk("b2b_valid1", {32'd0, if_m.out_valid}, 33'd1);
        idle(1);
        chk("b2b_valid2", {32'd0, if_m.out_valid}, 33'd0);
        idle(2);

        // backpressure: 100 pending, (1,2)+(3,3) must give 11 after release
        out_ready = 1'b0;
        send(10, 10, 1'b1); push(0, 1'b0, 32'd100);
        send(1, 2, 1'b0);
        chk("bp_valid", {32'd0, if_m.out_valid}, 33'd1);
        in_valid = 1'b1; in_a = 8'd3; in_b = 8'd3; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", {32'd0, if_m.in_ready}, 33'd0);
            chk("bp_hold", {if_m.out_sat, if_m.out_acc}, {1'b0, 32'd100});
            @(negedge clk);
            chk("bp_fwd", {32'd0, if_m.fwd_valid}, 33'd0);
        end
        out_ready = 1'b1;
        #1 chk("bp_release", {32'd0, if_m.in_ready}, 33'd1);
        @(negedge clk);
        in_valid = 1'b0;
        push(0, 1'b0, 32'd11);
        idle(4);

        // acc_clear does not disturb a pending result
        out_ready = 1'b0;
        send(7, 7, 1'b1); push(0, 1'b0, 32'd49);
        idle(2);
        acc_clear = 1'b1;
        #1 chk("clr_in_ready", {32'd0, if_m.in_ready}, 33'd0);
        @(negedge clk);
        chk("clr_pending", {if_m.out_valid, if_m.out_acc}, {1'b1, 32'd49});
        acc_clear = 1'b0;
        out_ready = 1'b1;
        idle(3);

        // acc_clear held two cycles mid-frame
        send(5, 5, 1'b0);
        send(6, 6, 1'b0);
        acc_clear = 1'b1;
        idle(2);
        acc_clear = 1'b0;
        send(2, 2, 1'b1); push(0, 1'b0, 32'd4);
        idle(4);

        // reset mid-frame: outputs clear without a clock edge
        send(9, 9, 1'b0);
        send(1, 1, 1'b0);
        #1 reset = 1'b0;
        #1;
        chk("rst_mid_out", {if_m.out_valid, if_m.out_acc}, 33'd0);
        chk("rst_mid_fwd", {15'd0, if_m.fwd_valid, if_m.a_fwd, if_m.b_fwd, 1'b0}, 33'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send(2, 2, 1'b1); push(0, 1'b0, 32'd4);
        idle(4);

        // 16-bit signed saturating: 3 x 16129 clamps to 32767
        sel = 2'd1;
        send(127, 127, 1'b0); send(127, 127, 1'b0); send(127, 127, 1'b1);
        push(1, 1'b1, 32'h7FFF);
        idle(4);

        // 16-bit signed wrapping: 48387 = 0xBD03 (-17149)
        sel = 2'd2;
        send(127, 127, 1'b0); send(127, 127, 1'b0); send(127, 127, 1'b1);
        push(2, 1'b1, 32'hBD03);
        idle(4);

        // 16-bit unsigned saturating
        sel = 2'd3;
        send(255, 255, 1'b1); push(3, 1'b0, 32'hFE01);
        send(255, 255, 1'b0);
        send(255, 255, 1'b1); push(3, 1'b1, 32'hFFFF);
        idle(5);

        chk("drain_m", 33'(q0.size()), 33'd0);
        chk("drain_s", 33'(q1.size()), 33'd0);
        chk("drain_w", 33'(q2.size()), 33'd0);
        chk("drain_u", 33'(q3.size()), 33'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
